mac_sequencer: RTL

Controller for the operand-memory / shift-add multiplier / accumulator datapath. On `start` it walks the operand memory in pairs (even address = multiplicand, odd address = multiplier). For each pair it drives a MUL_W-iteration shift-add multiply and accumulates the product. It then holds `done` until acknowledged. It owns every datapath control strobe and the memory address; the datapath owns all data registers.

---
 rtl/mac_ctrl_pkg.sv | 23 ++
 rtl/mac_sequencer_if.sv | 34 +++
 rtl/up_counter.sv | 20 ++
 rtl/mac_sequencer.sv | 108 ++++++++++
 4 files changed

// File: rtl/mac_ctrl_pkg.sv
// Shared encodings and default geometry for the MAC sequencer.
package mac_ctrl_pkg;
  localparam int DEF_ADDR_W = 4;
  localparam int DEF_MUL_W  = 8;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] CLEAR  = 3'd1;
  localparam logic [2:0] LOAD_A = 3'd2;
  localparam logic [2:0] LOAD_B = 3'd3;
  localparam logic [2:0] MUL    = 3'd4;
  localparam logic [2:0] ACCUM  = 3'd5;
  localparam logic [2:0] FINISH = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE   = IDLE,
    ST_CLEAR  = CLEAR,
    ST_LOAD_A = LOAD_A,
    ST_LOAD_B = LOAD_B,
    ST_MUL    = MUL,
    ST_ACCUM  = ACCUM,
    ST_FINISH = FINISH
  } state_e;
endpackage

// File: rtl/mac_sequencer_if.sv
// Controller <-> datapath strobe bundle. Optional abort input under ABORT_EN.
interface mac_sequencer_if #(parameter int ADDR_W = 4);
  logic              start;
  logic              q0;
  logic [ADDR_W-1:0] addr;
  logic              ld_a;
  logic              ld_b;
  logic              add_en;
  logic              shift_en;
  logic              acc_clr;
  logic              acc_en;
  logic              busy;
  logic              sel;
  logic              done;
`ifdef ABORT_EN
  logic              abort;
`endif

  modport master (
    input  start, q0,
    output addr, ld_a, ld_b, add_en, shift_en, acc_clr, acc_en, busy, sel, done
`ifdef ABORT_EN
    , input abort
`endif
  );

  modport slave (
    output start, q0,
    input  addr, ld_a, ld_b, add_en, shift_en, acc_clr, acc_en, busy, sel, done
`ifdef ABORT_EN
    , output abort
`endif
  );
endinterface

// File: rtl/up_counter.sv
// Up counter with sync clear (priority over enable) and terminal-count flag.
module up_counter #(
  parameter int           W   = 3,
  parameter logic [W-1:0] MAX = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] q,
  output logic         carry_out
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      q <= '0;
    else if (clr) q <= '0;
    else if (en)  q <= q + 1'b1;
  end

  assign carry_out = (q == MAX);
endmodule

// File: rtl/mac_sequencer.sv
// Pairwise shift-add MAC controller; drives all datapath strobes and the address.
// Optional ABORT_EN macro adds an abort input that returns a busy run to IDLE.
module mac_sequencer
  import mac_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int MUL_W  = DEF_MUL_W
) (
  input  logic clk,
  input  logic rst,
  mac_sequencer_if.master bus
);
  localparam int KW = ADDR_W - 1;
  localparam int IW = (MUL_W > 1) ? $clog2(MUL_W) : 1;

  state_e state, nxt;
  logic [KW-1:0] k;
  logic [IW-1:0] i;
  logic k_en, k_clr, k_last, i_en, i_clr, i_last;
  logic [ADDR_W-1:0] addr;
  logic ld_a, ld_b, add_en, shift_en, acc_clr, acc_en, busy, sel, done;
  logic unused_i;

  up_counter #(.W(KW), .MAX(KW'(2**KW - 1))) u_k (
    .clk(clk), .rst(rst), .en(k_en), .clr(k_clr), .q(k), .carry_out(k_last)
  );

  // Only the terminal-count flag of the iteration counter steers the FSM.
  up_counter #(.W(IW), .MAX(IW'(MUL_W - 1))) u_i (
    .clk(clk), .rst(rst), .en(i_en), .clr(i_clr), .q(i), .carry_out(i_last)
  );
  assign unused_i = ^i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt      = state;
    addr     = '0;
    ld_a     = 1'b0;
    ld_b     = 1'b0;
    add_en   = 1'b0;
    shift_en = 1'b0;
    acc_clr  = 1'b0;
    acc_en   = 1'b0;
    busy     = 1'b0;
    sel      = 1'b0;
    done     = 1'b0;
    k_en     = 1'b0;
    k_clr    = 1'b0;
    i_en     = 1'b0;
    i_clr    = 1'b0;
    case (state)
      ST_IDLE: if (bus.start) nxt = ST_CLEAR;
      ST_CLEAR: begin
        busy = 1'b1; acc_clr = 1'b1; k_clr = 1'b1;
        nxt  = ST_LOAD_A;
      end
      ST_LOAD_A: begin
        busy = 1'b1; ld_a = 1'b1; addr = {k, 1'b0};
        nxt  = ST_LOAD_B;
      end
      ST_LOAD_B: begin
        busy = 1'b1; ld_b = 1'b1; addr = {k, 1'b1}; i_clr = 1'b1;
        nxt  = ST_MUL;
      end
      ST_MUL: begin
        // add_en follows q0 combinationally: add and shift land on the same edge
        busy = 1'b1; shift_en = 1'b1; add_en = bus.q0;
        if (i_last) nxt = ST_ACCUM;
        else        i_en = 1'b1;
      end
      ST_ACCUM: begin
        busy = 1'b1; acc_en = 1'b1;
        if (k_last) nxt = ST_FINISH;
        else begin
          k_en = 1'b1;
          nxt  = ST_LOAD_A;
        end
      end
      ST_FINISH: begin
        done = 1'b1; sel = 1'b1;
        if (bus.start) nxt = ST_IDLE;
      end
      default: nxt = ST_IDLE;
    endcase
`ifdef ABORT_EN
    if (bus.abort && busy) begin
      nxt   = ST_IDLE;
      k_clr = 1'b1;
      i_clr = 1'b1;
    end
`endif
  end

  assign bus.addr     = addr;
  assign bus.ld_a     = ld_a;
  assign bus.ld_b     = ld_b;
  assign bus.add_en   = add_en;
  assign bus.shift_en = shift_en;
  assign bus.acc_clr  = acc_clr;
  assign bus.acc_en   = acc_en;
  assign bus.busy     = busy;
  assign bus.sel      = sel;
  assign bus.done     = done;
endmodule
